booth_multiple_gen: RTL and testbench
=====================================

Name: booth_multiple_gen

Overview:
Successor to the plain multiplicand register for the radix-16 Booth multiplier. Captures a WIDTH-bit multiplicand X through a valid/ready handshake. Generates the full set of Booth multiples 1X..8X sequentially, using one shared adder/subtractor. Presents all eight multiples as registered outputs to the partial-product selector, with an output valid/ready handshake and back-to-back reload.

Parameters:
WIDTH, 8, multiplicand width in bits (>= 2)
SIGNED, 1, 1 = X is two's complement (sign-extend), 0 = unsigned (zero-extend)

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  reset, asynchronous and active-high
flush  input  1  synchronous abort: return to IDLE, clear outputs
in_valid  input  1  multiplicand valid
in_ready  output  1  block can accept a multiplicand this cycle
din  input  WIDTH  multiplicand X
out_valid  output  1  m1..m8 complete and stable
out_ready  input  1  consumer has taken the multiples
m1..m8  output  WIDTH+3 each  registered multiples kX, k = 1..8, in MW = WIDTH+3 bits (extended per SIGNED)

Behaviour:
- Reset (rst = 1, any time, including mid-computation):
  - state = IDLE; m1..m8 = 0; out_valid = 0; in_ready = 1 after the reset release edge.
- FSM states: IDLE, CALC3, CALC5, CALC7, DONE.
- in_ready = (state == IDLE) or (state == DONE and out_ready).
- Accept = in_valid and in_ready. On the accept edge:
  - X is extended to MW bits.
  - m1 = X, m2 = X<<1, m4 = X<<2, m8 = X<<3.
  - m3, m5, m6, m7 are not yet valid; they are held at their old values and must not be consumed.
  - Next state = CALC3.
- CALC3 edge: m3 = m2 + m1; m6 = (m2 + m1) << 1. Next state = CALC5.
- CALC5 edge: m5 = m4 + m1. Next state = CALC7.
- CALC7 edge: m7 = m8 - m1. Next state = DONE.
- Shared adder:
  - Exactly one MW-bit adder/subtractor. Operand muxes are driven by the state.
  - No overflow is possible at MW = WIDTH+3, in either mode.
  - Unsigned 255 -> 8X = 2040 < 2048; signed -128 -> 8X = -1024.
- Latency and output handshake:
  - out_valid = 1 exactly while state == DONE, i.e. 3 edges after the accept edge.
  - The first valid cycle is the 4th rising edge counting the accept edge as 1.
  - In DONE, m1..m8 hold until out_valid and out_ready.
  - out_valid stays high indefinitely while out_ready = 0 (backpressure).
- Output taken with no new input (out_valid and out_ready, in_valid = 0):
  - next state = IDLE; out_valid falls; m1..m8 keep their last values (not cleared).
- Output taken and new input in the same cycle (out_valid, out_ready, in_valid all high):
  - the new X is accepted; next state = CALC3; out_valid falls next cycle.
  - Sustained throughput is therefore one multiplicand per 4 cycles.
- in_valid while busy (CALC3/5/7, or DONE without out_ready):
  - in_ready = 0, so nothing is accepted; din is ignored. The producer must hold its request.
- flush = 1 (synchronous, any state):
  - next state = IDLE; m1..m8 = 0; out_valid = 0.
  - flush has priority over accept and over output handshake in the same cycle.
  - rst has priority over flush.
- Extension: SIGNED = 1 replicates din[WIDTH-1]; SIGNED = 0 pads zeros. All arithmetic is MW-bit two's complement.

Test Plan:
1. Reset: assert rst mid-CALC5 -> out_valid = 0, m1..m8 = 0, in_ready = 1 after release; no stale DONE afterwards.
2. WIDTH=8, SIGNED=1, din = 0xFD (-3), out_ready = 1 -> out_valid on the 4th edge with 11-bit values: m1 = -3, m2 = -6, m3 = -9, m4 = -12, m5 = -15, m6 = -18, m7 = -21, m8 = -24; then return to IDLE.
3. WIDTH=8, SIGNED=0, din = 0xFF -> m1 = 255, m3 = 765, m5 = 1275, m6 = 1530, m7 = 1785, m8 = 2040; SIGNED=1 with din = 0x80 -> m8 = -1024, m7 = -896.
4. Backpressure: out_ready = 0 for 10 cycles after DONE -> out_valid stays 1, outputs stable, in_ready = 0, a new in_valid is not accepted; out_ready = 1 -> handshake completes.
5. Back-to-back: in_valid held high with din = 5 then 7, out_ready = 1 -> accepts at cycles 0 and 4, out_valid in cycles 3 and 7, m7 = 35 then 49.
6. flush asserted in CALC3 and in DONE with out_ready = 1 and in_valid = 1 -> IDLE, outputs 0, no accept, no out handshake counted.

Source files
------------

// File: rtl/booth_multiple_gen.sv
// Radix-16 Booth multiple generator: captures X, then builds 1X..8X over three
// extra cycles on one shared adder/subtractor, and holds them for the selector.
module booth_multiple_gen #(
   parameter int unsigned WIDTH  = 8,
   parameter bit          SIGNED = 1'b1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 flush,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [WIDTH-1:0]     din,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [WIDTH+2:0]     m1,
   output logic [WIDTH+2:0]     m2,
   output logic [WIDTH+2:0]     m3,
   output logic [WIDTH+2:0]     m4,
   output logic [WIDTH+2:0]     m5,
   output logic [WIDTH+2:0]     m6,
   output logic [WIDTH+2:0]     m7,
   output logic [WIDTH+2:0]     m8
);

   localparam int unsigned MW = WIDTH + 3;

   typedef enum logic [2:0] {IDLE, CALC3, CALC5, CALC7, DONE} state_t;

   state_t          r_state;
   logic [MW-1:0]   r_m1, r_m2, r_m3, r_m4, r_m5, r_m6, r_m7, r_m8;
   logic [MW-1:0]   w_x_ext;
   logic [MW-1:0]   w_op_a;
   logic [MW-1:0]   w_op_b;
   logic            w_sub;
   logic [MW-1:0]   w_sum;
   logic            w_accept;

   assign w_x_ext  = {{3{din[WIDTH-1] & SIGNED}}, din};
   assign in_ready = (r_state == IDLE) || ((r_state == DONE) && out_ready);
   assign out_valid = (r_state == DONE);
   assign w_accept = in_valid && in_ready;

   // Single shared adder; subtraction via inverted operand plus carry-in.
   always_comb begin
      w_op_a = r_m2;
      w_op_b = r_m1;
      w_sub  = 1'b0;
      unique case (r_state)
         CALC5: w_op_a = r_m4;
         CALC7: begin
            w_op_a = r_m8;
            w_sub  = 1'b1;
         end
         default: w_op_a = r_m2;
      endcase
   end

   assign w_sum = w_op_a + (w_sub ? ~w_op_b : w_op_b) + {{(MW-1){1'b0}}, w_sub};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= IDLE;
         r_m1 <= '0; r_m2 <= '0; r_m3 <= '0; r_m4 <= '0;
         r_m5 <= '0; r_m6 <= '0; r_m7 <= '0; r_m8 <= '0;
      end else if (flush) begin
         r_state <= IDLE;
         r_m1 <= '0; r_m2 <= '0; r_m3 <= '0; r_m4 <= '0;
         r_m5 <= '0; r_m6 <= '0; r_m7 <= '0; r_m8 <= '0;
      end else if (w_accept) begin
         r_state <= CALC3;
         r_m1    <= w_x_ext;
         r_m2    <= {w_x_ext[MW-2:0], 1'b0};
         r_m4    <= {w_x_ext[MW-3:0], 2'b00};
         r_m8    <= {w_x_ext[MW-4:0], 3'b000};
      end else begin
         unique case (r_state)
            CALC3: begin
               r_m3    <= w_sum;
               r_m6    <= {w_sum[MW-2:0], 1'b0};
               r_state <= CALC5;
            end
            CALC5: begin
               r_m5    <= w_sum;
               r_state <= CALC7;
            end
            CALC7: begin
               r_m7    <= w_sum;
               r_state <= DONE;
            end
            DONE: begin
               if (out_ready) r_state <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign m1 = r_m1;
   assign m2 = r_m2;
   assign m3 = r_m3;
   assign m4 = r_m4;
   assign m5 = r_m5;
   assign m6 = r_m6;
   assign m7 = r_m7;
   assign m8 = r_m8;

endmodule

// File: tb/tb_booth_multiple_gen.sv
// Bench: signed and unsigned instances share stimulus; multiples checked against
// k * extended(X) computed with plain integer arithmetic.
module tb_booth_multiple_gen;

   logic        clk = 1'b0;
   logic        rst, flush, in_valid, out_ready;
   logic [7:0]  din;
   logic        s_in_ready, s_out_valid, u_in_ready, u_out_valid;
   logic [10:0] sm1, sm2, sm3, sm4, sm5, sm6, sm7, sm8;
   logic [10:0] um1, um2, um3, um4, um5, um6, um7, um8;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   booth_multiple_gen #(.WIDTH(8), .SIGNED(1'b1)) u_dut_s (
      .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(s_in_ready),
      .din(din), .out_valid(s_out_valid), .out_ready(out_ready),
      .m1(sm1), .m2(sm2), .m3(sm3), .m4(sm4), .m5(sm5), .m6(sm6), .m7(sm7), .m8(sm8)
   );

   booth_multiple_gen #(.WIDTH(8), .SIGNED(1'b0)) u_dut_u (
      .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(u_in_ready),
      .din(din), .out_valid(u_out_valid), .out_ready(out_ready),
      .m1(um1), .m2(um2), .m3(um3), .m4(um4), .m5(um5), .m6(um6), .m7(um7), .m8(um8)
   );

   typedef struct {
      logic [7:0]  x;
      logic [10:0] s_m7;
      logic [10:0] u_m8;
      int          bp;
   } vec_t;

   vec_t vecs[6];

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic chk(input string name, input int idx, input int got, input int exp);
      n_vec++;
      if (got != exp) begin
         n_err++;
         $display("FAIL %s[%0d] got %0d expected %0d at %0t", name, idx, got, exp, $time);
      end
   endtask

   // Reference: kX as MW-bit two's complement of k times the extended multiplicand.
   function automatic int kx(input logic [7:0] x, input int k, input bit sgn);
      int v;
      logic [10:0] r;
      v = sgn ? int'($signed(x)) : int'(x);
      r = 11'(v * k);
      return int'(r);
   endfunction

   function automatic int get_m(input int k, input bit sgn);
      logic [10:0] r;
      case (k)
         1: r = sgn ? sm1 : um1;
         2: r = sgn ? sm2 : um2;
         3: r = sgn ? sm3 : um3;
         4: r = sgn ? sm4 : um4;
         5: r = sgn ? sm5 : um5;
         6: r = sgn ? sm6 : um6;
         7: r = sgn ? sm7 : um7;
         default: r = sgn ? sm8 : um8;
      endcase
      return int'(r);
   endfunction

   task automatic check_all(input logic [7:0] x, input string tag);
      for (int k = 1; k <= 8; k++) begin
         chk({tag, "_s_m"}, k, get_m(k, 1'b1), kx(x, k, 1'b1));
         chk({tag, "_u_m"}, k, get_m(k, 1'b0), kx(x, k, 1'b0));
      end
   endtask

   task automatic check_zero(input string tag);
      for (int k = 1; k <= 8; k++) begin
         chk({tag, "_s_m"}, k, get_m(k, 1'b1), 0);
         chk({tag, "_u_m"}, k, get_m(k, 1'b0), 0);
      end
      chk({tag, "_s_out_valid"}, 0, int'(s_out_valid), 0);
      chk({tag, "_u_out_valid"}, 0, int'(u_out_valid), 0);
   endtask

   // Accept from IDLE, wait for DONE, optionally apply backpressure, hand off.
   task automatic run_one(input logic [7:0] x, input int bp);
      int n;
      in_valid  = 1'b1;
      din       = x;
      out_ready = (bp == 0);
      #1;
      chk("in_ready_idle", 0, int'(s_in_ready), 1);
      tick();
      in_valid = 1'b0;
      din      = 8'($urandom);
      n = 1;
      while (!s_out_valid && n < 10) begin
         tick();
         n++;
      end
      chk("latency_edges", 0, n, 4);
      chk("u_out_valid", 0, int'(u_out_valid), 1);
      check_all(x, "done");
      if (bp > 0) begin
         in_valid = 1'b1;
         din      = ~x;
         for (int i = 0; i < bp; i++) begin
            #1;
            chk("bp_in_ready", i, int'(s_in_ready), 0);
            tick();
            chk("bp_out_valid", i, int'(s_out_valid), 1);
         end
         in_valid = 1'b0;
         check_all(x, "bp_hold");
         out_ready = 1'b1;
      end
      tick();
      out_ready = 1'b0;
      chk("taken_out_valid", 0, int'(s_out_valid), 0);
      chk("taken_in_ready", 0, int'(s_in_ready), 1);
      check_all(x, "kept");
   endtask

   initial begin
      vecs[0] = '{x: 8'hFD, s_m7: 11'h7EB, u_m8: 11'd2024, bp: 0};  // -21, 253*8
      vecs[1] = '{x: 8'hFF, s_m7: 11'd2041, u_m8: 11'd2040, bp: 0};
      vecs[2] = '{x: 8'h80, s_m7: 11'd1152, u_m8: 11'd1024, bp: 2};  // -896, -1024
      vecs[3] = '{x: 8'h7F, s_m7: 11'd889, u_m8: 11'd1016, bp: 10};
      vecs[4] = '{x: 8'h00, s_m7: 11'd0, u_m8: 11'd0, bp: 0};
      vecs[5] = '{x: 8'h01, s_m7: 11'd7, u_m8: 11'd8, bp: 1};

      rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; din = '0;
      #12;
      check_zero("reset");
      rst = 1'b0;
      tick();
      chk("reset_in_ready", 0, int'(s_in_ready), 1);

      for (int i = 0; i < 6; i++) begin
         run_one(vecs[i].x, vecs[i].bp);
         chk("tbl_s_m7", i, int'(sm7), int'(vecs[i].s_m7));
         chk("tbl_u_m8", i, int'(um8), int'(vecs[i].u_m8));
      end

      // Asynchronous reset mid-CALC5.
      in_valid = 1'b1; din = 8'h33;
      tick();
      in_valid = 1'b0;
      tick();
      #1 rst = 1'b1;
      #1;
      check_zero("async_rst");
      #3 rst = 1'b0;
      #1;
      chk("rst_rel_in_ready", 0, int'(s_in_ready), 1);
      for (int i = 0; i < 6; i++) begin
         tick();
         chk("no_stale_done", i, int'(s_out_valid), 0);
      end

      // Back-to-back: 5 then 7 with in_valid held high.
      out_ready = 1'b1; in_valid = 1'b1; din = 8'd5;
      tick();
      din = 8'd7;
      tick(); tick();
      chk("b2b_pre_valid", 0, int'(s_out_valid), 0);
      tick();
      chk("b2b_valid0", 0, int'(s_out_valid), 1);
      chk("b2b_m7_0", 0, int'(sm7), 35);
      chk("b2b_in_ready", 0, int'(s_in_ready), 1);
      tick();
      in_valid = 1'b0;
      chk("b2b_drop", 0, int'(s_out_valid), 0);
      chk("b2b_m1_new", 0, int'(sm1), 7);
      tick(); tick();
      chk("b2b_pre_valid", 1, int'(s_out_valid), 0);
      tick();
      chk("b2b_valid1", 0, int'(s_out_valid), 1);
      chk("b2b_m7_1", 0, int'(um7), 49);
      tick();
      out_ready = 1'b0;
      chk("b2b_idle", 0, int'(s_out_valid), 0);

      // Flush in CALC3.
      in_valid = 1'b1; din = 8'h9C;
      tick();
      in_valid = 1'b0; flush = 1'b1;
      tick();
      flush = 1'b0;
      check_zero("flush_calc3");
      chk("flush_calc3_in_ready", 0, int'(s_in_ready), 1);

      // Flush in DONE beats both the output handshake and a new accept.
      in_valid = 1'b1; din = 8'h21;
      tick();
      in_valid = 1'b0;
      tick(); tick(); tick();
      chk("pre_flush_done", 0, int'(s_out_valid), 1);
      out_ready = 1'b1; in_valid = 1'b1; din = 8'h44; flush = 1'b1;
      tick();
      flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      check_zero("flush_done");
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("flush_no_accept_m1", i, int'(sm1), 0);
         chk("flush_no_accept_ov", i, int'(s_out_valid), 0);
      end

      // Randomized multiplicands with random backpressure.
      for (int i = 0; i < 40; i++) begin
         run_one(8'($urandom), int'($urandom_range(0, 3)));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
